// File: rtl/secded_decoder.sv
// secded_decoder: two-stage SECDED check/correct pipeline for 40-bit codewords
// from Parity_Encoder, returning the 32-bit payload with correction flags and
// saturating error-statistics counters.
//
// Stage 1 captures the syndrome, overall parity and raw data. Stage 2
// classifies the error and repairs a single flipped data bit. Both stages
// advance together whenever the output register is empty or being drained.
module secded_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [39:0]      in_codeword,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_corrected,
    output logic             out_uncorrectable,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count
);

    // Highest Hamming position that holds a data bit (d31).
    localparam int LAST_POS = 38;

    // Hamming position of each data bit d0..d31.
    typedef logic [31:0][5:0] pos_tab_t;

    // Data bits fill positions 3..38 in order, skipping powers of two
    // (those positions belong to the check bits).
    function automatic pos_tab_t build_pos_tab();
        pos_tab_t   tab;
        logic [4:0] k;
        tab = '0;
        k   = '0;
        for (int p = 3; p <= LAST_POS; p++) begin
            if ((p & (p - 1)) != 0) begin
                tab[k] = 6'(p);
                k      = k + 5'd1;
            end
        end
        return tab;
    endfunction

    localparam pos_tab_t         DATA_POS = build_pos_tab();
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic        adv;
    logic        out_fire;
    logic [31:0] in_data;
    logic [5:0]  syn_calc;
    logic        par_calc;

    logic        s1_valid;
    logic [5:0]  s1_syn;
    logic        s1_par;
    logic [31:0] s1_data;

    logic        syn_pow2;
    logic [31:0] flip_mask;
    logic [31:0] fix_data;
    logic        fix_corr;
    logic        fix_unc;

    // The whole pipe moves whenever the output slot is free or being taken.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign out_fire = out_valid && out_ready;
    assign in_data  = in_codeword[31:0];

    // Syndrome: XOR of the positions of all set data bits, folded with the
    // received check bits; bit 39 is reserved and never looked at.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // so no path through the block can infer a latch.
        syn_calc = in_codeword[37:32];
        for (int j = 0; j < 32; j++) begin
            if (in_data[j[4:0]]) begin
                syn_calc = syn_calc ^ DATA_POS[j[4:0]];
            end
        end
        par_calc = ^in_codeword[38:0];
    end

    // Stage 1 register: syndrome, overall parity and raw data.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples the
        // values from before the edge, independent of statement order.
        if (rst) begin
            s1_valid <= 1'b0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
            s1_data  <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_syn   <= syn_calc;
            s1_par   <= par_calc;
            s1_data  <= in_data;
        end
    end

    // Classify the stage-1 syndrome and repair a single data-bit error.
    always_comb begin
        syn_pow2 = ((s1_syn & (s1_syn - 6'd1)) == 6'd0);
        for (int j = 0; j < 32; j++) begin
            flip_mask[j[4:0]] = (s1_syn == DATA_POS[j[4:0]]);
        end
        fix_data = s1_data;
        fix_corr = 1'b0;
        fix_unc  = 1'b0;
        if (s1_syn == 6'd0) begin
            // Either clean, or only the overall-parity bit flipped.
            fix_corr = s1_par;
        end else if (!s1_par) begin
            // Even number of flips with a nonzero syndrome: double error.
            fix_unc = 1'b1;
        end else if (syn_pow2) begin
            // A check bit flipped; the payload is intact.
            fix_corr = 1'b1;
        end else if (s1_syn > 6'(LAST_POS)) begin
            // Odd error count pointing past the codeword: multi-bit error.
            fix_unc = 1'b1;
        end else begin
            fix_data = s1_data ^ flip_mask;
            fix_corr = 1'b1;
        end
    end

    // Stage 2 register: presented word and flags, held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
        end else if (adv) begin
            out_valid         <= s1_valid;
            out_data          <= fix_data;
            out_corrected     <= s1_valid && fix_corr;
            out_uncorrectable <= s1_valid && fix_unc;
        end
    end

    // Corrected-word counter: counts delivered words, clear wins, saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_count <= '0;
        end else if (cnt_clear) begin
            corr_count <= '0;
        end else if (out_fire && out_corrected && corr_count != CNT_MAX) begin
            corr_count <= corr_count + CNT_W'(1);
        end
    end

    // Uncorrectable-word counter: same rules as the corrected counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uncorr_count <= '0;
        end else if (cnt_clear) begin
            uncorr_count <= '0;
        end else if (out_fire && out_uncorrectable && uncorr_count != CNT_MAX) begin
            uncorr_count <= uncorr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_secded_decoder.sv
// tb_secded_decoder: scoreboard bench for secded_decoder. Expected results
// come from a brute-force reference (re-encode, then try every single flip)
// and are queued when a word is accepted and popped when a word is delivered.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_secded_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] in_codeword;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_corrected;
    logic        out_uncorrectable;
    logic        cnt_clear;
    logic [15:0] corr_count;
    logic [15:0] uncorr_count;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic        s_out_corrected;
    logic        s_out_uncorrectable;
    logic [1:0]  s_corr_count;
    logic [1:0]  s_uncorr_count;

    typedef struct {
        logic [31:0] data;
        logic        corr;
        logic        unc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_corr = 0;
    int   exp_unc = 0;
    int   exp_corr_s = 0;
    int   exp_unc_s = 0;

    always #5 clk = ~clk;

    secded_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_codeword(in_codeword),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable),
        .cnt_clear(cnt_clear), .corr_count(corr_count), .uncorr_count(uncorr_count)
    );

    secded_decoder #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_codeword(in_codeword),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_corrected(s_out_corrected), .out_uncorrectable(s_out_uncorrectable),
        .cnt_clear(cnt_clear), .corr_count(s_corr_count), .uncorr_count(s_uncorr_count)
    );

    // Reference encoder: {overall parity, c[5:0], data}.
    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] hv;
        logic [5:0]  c;
        int          k;
        hv = '0;
        c  = '0;
        k  = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                hv[p] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 38; p++) begin
            if (hv[p]) c = c ^ 6'(p);
        end
        return {^{c, d}, c, d};
    endfunction

    // Reference decoder: a word within one flip of a valid codeword is
    // correctable, anything else that is not itself valid is not.
    function automatic exp_t predict(input logic [39:0] cw);
        exp_t        e;
        logic [38:0] w;
        logic [38:0] t;
        w      = cw[38:0];
        e.data = w[31:0];
        e.corr = 1'b0;
        e.unc  = 1'b0;
        if (encode(w[31:0]) == w) return e;
        for (int b = 0; b < 39; b++) begin
            t = w;
            t[b] = ~t[b];
            if (encode(t[31:0]) == t) begin
                e.data = t[31:0];
                e.corr = 1'b1;
                return e;
            end
        end
        e.unc = 1'b1;
        return e;
    endfunction

    // Valid codeword with nflip distinct bits flipped and a random bit 39.
    function automatic logic [39:0] make_cw(input logic [31:0] d, input int nflip);
        logic [38:0] w;
        int          b0, b1, b2;
        w  = encode(d);
        b0 = $urandom_range(0, 38);
        b1 = (b0 + 1 + $urandom_range(0, 37)) % 39;
        b2 = $urandom_range(0, 38);
        while (b2 == b0 || b2 == b1) b2 = (b2 + 1) % 39;
        if (nflip >= 1) w[b0] = ~w[b0];
        if (nflip >= 2) w[b1] = ~w[b1];
        if (nflip >= 3) w[b2] = ~w[b2];
        return {1'($urandom_range(0, 1)), w};
    endfunction

    // Scoreboard monitor, sampling on the falling edge: pop and compare on
    // each output handshake, push on each input handshake, track counters.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_output: got data %h with empty queue", out_data);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (out_data !== e.data) begin
                        n_bad++;
                        $display("FAIL out_data: got %h expected %h", out_data, e.data);
                    end
                    n_cmp++;
                    if (out_corrected !== e.corr || out_uncorrectable !== e.unc) begin
                        n_bad++;
                        $display("FAIL flags: got corr=%b unc=%b expected corr=%b unc=%b",
                                 out_corrected, out_uncorrectable, e.corr, e.unc);
                    end
                    if (!cnt_clear) begin
                        if (out_corrected) begin exp_corr++; if (exp_corr_s < 3) exp_corr_s++; end
                        if (out_uncorrectable) begin exp_unc++; if (exp_unc_s < 3) exp_unc_s++; end
                    end
                end
            end
            if (cnt_clear) begin
                exp_corr = 0; exp_unc = 0; exp_corr_s = 0; exp_unc_s = 0;
            end
            if (in_valid && in_ready) sb.push_back(predict(in_codeword));
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [39:0] cw, input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        in_valid    = v;
        in_codeword = cw;
        out_ready   = rdy;
        cnt_clear   = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic clear_model();
        sb.delete();
        exp_corr = 0; exp_unc = 0; exp_corr_s = 0; exp_unc_s = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_codeword = '0; out_ready = 1'b1; cnt_clear = 1'b0;
        clear_model();
        #12;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_corrected !== 1'b0 || out_uncorrectable !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%b u=%b expected all 0",
                     out_valid, out_data, out_corrected, out_uncorrectable);
        end
        n_cmp++;
        if (corr_count !== 16'd0 || uncorr_count !== 16'd0 || s_corr_count !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
                     corr_count, uncorr_count, s_corr_count);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    // Zero codeword raised in cycle 0 appears with out_valid in cycle 2.
    task automatic test_clean();
        drive(1'b1, 40'h0, 1'b1, 1'b0);
        drive(1'b0, 40'h0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: out_valid got %b expected 0", out_valid);
        end
        drive(1'b0, 40'h0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h0 || out_corrected !== 1'b0 || out_uncorrectable !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_word: got v=%b d=%h c=%b u=%b expected v=1 d=0 c=0 u=0",
                     out_valid, out_data, out_corrected, out_uncorrectable);
        end
        idle(3);
        n_cmp++;
        if (corr_count !== 16'd0 || uncorr_count !== 16'd0) begin
            n_bad++;
            $display("FAIL clean_counters: got %0d/%0d expected 0/0", corr_count, uncorr_count);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 40'h0000000001, 1'b1, 1'b0);
        drive(1'b0, 40'h0, 1'b1, 1'b0);
        drive(1'b0, 40'h0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h0 || out_corrected !== 1'b1 || out_uncorrectable !== 1'b0) begin
            n_bad++;
            $display("FAIL single_d0: got v=%b d=%h c=%b u=%b expected v=1 d=0 c=1 u=0",
                     out_valid, out_data, out_corrected, out_uncorrectable);
        end
        idle(2);
        n_cmp++;
        if (corr_count !== 16'd1) begin
            n_bad++;
            $display("FAIL single_count: corr_count got %0d expected 1", corr_count);
        end
    endtask

    task automatic test_double();
        drive(1'b1, 40'h0000000003, 1'b1, 1'b0);
        drive(1'b0, 40'h0, 1'b1, 1'b0);
        drive(1'b0, 40'h0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h3 || out_corrected !== 1'b0 || out_uncorrectable !== 1'b1) begin
            n_bad++;
            $display("FAIL double_d0d1: got v=%b d=%h c=%b u=%b expected v=1 d=3 c=0 u=1",
                     out_valid, out_data, out_corrected, out_uncorrectable);
        end
        idle(2);
        n_cmp++;
        if (uncorr_count !== 16'd1 || corr_count !== 16'd1) begin
            n_bad++;
            $display("FAIL double_count: got corr=%0d uncorr=%0d expected 1/1", corr_count, uncorr_count);
        end
    endtask

    // Overall-parity bit, check bit c0, and the reserved bit.
    task automatic test_special();
        logic [39:0] cws[3];
        logic        corr_exp[3];
        cws[0] = 40'h4000000000; corr_exp[0] = 1'b1;
        cws[1] = 40'h0100000000; corr_exp[1] = 1'b1;
        cws[2] = 40'h8000000000; corr_exp[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, cws[i], 1'b1, 1'b0);
            drive(1'b0, 40'h0, 1'b1, 1'b0);
            drive(1'b0, 40'h0, 1'b1, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 32'h0 || out_corrected !== corr_exp[i] || out_uncorrectable !== 1'b0) begin
                n_bad++;
                $display("FAIL special_%0d: got v=%b d=%h c=%b u=%b expected v=1 d=0 c=%b u=0",
                         i, out_valid, out_data, out_corrected, out_uncorrectable, corr_exp[i]);
            end
        end
        idle(2);
        n_cmp++;
        if (corr_count !== 16'd3 || uncorr_count !== 16'd1) begin
            n_bad++;
            $display("FAIL special_count: got corr=%0d uncorr=%0d expected 3/1", corr_count, uncorr_count);
        end
    endtask

    // Eight words back to back; consumer stalls in cycles 3..5.
    task automatic test_back_to_back();
        logic [39:0] words[8];
        logic [39:0] cw;
        logic [31:0] held_d;
        logic        held_c, held_u;
        logic [31:0] rnd;
        int          sent;
        sent = 0;
        held_d = '0; held_c = 1'b0; held_u = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rnd = $urandom;
            words[i] = make_cw(rnd, i % 3);
        end
        for (int c = 0; c < 40 && sent < 8; c++) begin
            cw = words[sent];
            drive(1'b1, cw, !(c >= 3 && c <= 5), 1'b0);
            #1;
            if (c >= 3 && c <= 5) begin
                n_cmp++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stall_handshake_c%0d: got in_ready=%b out_valid=%b expected 0/1",
                             c, in_ready, out_valid);
                end
                if (c == 3) begin
                    held_d = out_data; held_c = out_corrected; held_u = out_uncorrectable;
                end else begin
                    n_cmp++;
                    if (out_data !== held_d || out_corrected !== held_c || out_uncorrectable !== held_u) begin
                        n_bad++;
                        $display("FAIL stall_stable_c%0d: got d=%h c=%b u=%b expected d=%h c=%b u=%b",
                                 c, out_data, out_corrected, out_uncorrectable, held_d, held_c, held_u);
                    end
                end
            end
            if (in_valid && in_ready) sent++;
        end
        n_cmp++;
        if (sent != 8) begin
            n_bad++;
            $display("FAIL b2b_accept: accepted %0d expected 8", sent);
        end
        idle(5);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_drain: %0d words outstanding expected 0", sb.size());
        end
    endtask

    // Random valid/ready with 0..3 flipped bits per word.
    task automatic test_random();
        logic [31:0] rnd;
        for (int i = 0; i < 200; i++) begin
            rnd = $urandom;
            drive($urandom_range(0, 3) != 0, make_cw(rnd, $urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, 1'b0);
        end
        idle(6);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL random_drain: %0d words outstanding expected 0", sb.size());
        end
        n_cmp++;
        if (corr_count !== 16'(exp_corr) || uncorr_count !== 16'(exp_unc)) begin
            n_bad++;
            $display("FAIL random_counters: got %0d/%0d expected %0d/%0d",
                     corr_count, uncorr_count, exp_corr, exp_unc);
        end
        n_cmp++;
        if (s_corr_count !== 2'(exp_corr_s) || s_uncorr_count !== 2'(exp_unc_s)) begin
            n_bad++;
            $display("FAIL random_small_counters: got %0d/%0d expected %0d/%0d",
                     s_corr_count, s_uncorr_count, exp_corr_s, exp_unc_s);
        end
    endtask

    // Reset in the middle of a stream discards everything in flight.
    task automatic test_reset_midstream();
        logic [31:0] rnd;
        for (int i = 0; i < 3; i++) begin
            rnd = $urandom;
            drive(1'b1, make_cw(rnd, 1), 1'b1, 1'b0);
        end
        @(posedge clk);
        #3;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_pre: out_valid got %b expected 1", out_valid);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_corrected !== 1'b0 || corr_count !== 16'd0) begin
            n_bad++;
            $display("FAIL midreset_async: got v=%b d=%h c=%b cnt=%0d expected 0/0/0/0",
                     out_valid, out_data, out_corrected, corr_count);
        end
        clear_model();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_flush: out_valid got %b expected 0", out_valid);
        end
    endtask

    // CNT_W=2 saturates at 3; a clear on the same edge as an increment wins.
    task automatic test_saturation();
        logic [31:0] rnd;
        bit          hit;
        drive(1'b0, 40'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            rnd = $urandom;
            drive(1'b1, make_cw(rnd, 1), 1'b1, 1'b0);
        end
        idle(4);
        n_cmp++;
        if (s_corr_count !== 2'd3 || corr_count !== 16'd5) begin
            n_bad++;
            $display("FAIL saturate: got small=%0d wide=%0d expected 3/5", s_corr_count, corr_count);
        end
        rnd = $urandom;
        drive(1'b1, make_cw(rnd, 1), 1'b1, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            drive(1'b0, 40'h0, 1'b1, 1'b0);
            #1;
            if (out_valid) begin
                cnt_clear = 1'b1;
                hit = 1'b1;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL clear_collide_timeout: out_valid got 0 expected 1 within 10 cycles");
        end
        drive(1'b0, 40'h0, 1'b1, 1'b0);
        n_cmp++;
        if (s_corr_count !== 2'd0 || corr_count !== 16'd0 || uncorr_count !== 16'd0) begin
            n_bad++;
            $display("FAIL clear_priority: got small=%0d wide=%0d uncorr=%0d expected 0/0/0",
                     s_corr_count, corr_count, uncorr_count);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_special();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        test_saturation();
        idle(3);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL final_drain: %0d words outstanding expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
